pipeline_ifp_fetch_ctrl: RTL and testbench

Instruction Fetch Prepare stage; sits directly upstream of the instruction-fetch-ready stage.
- Owns the architectural fetch PC and computes next-PC (sequential, redirect, hold).
- Decodes the PC into the ROM or DRAM channel.
- Runs the DRAM fetch request/ready handshake.
- Raises a fetch stall while a DRAM fetch is outstanding.
- Provides pc_IFP and if_channel_sel, which the downstream stage registers together with rom_dout/dram_dout.

---
 rtl/pipeline_ifp_pkg.sv | 7 +
 rtl/pipeline_ifp_fetch_ctrl_addr_decode.sv | 12 +
 rtl/pipeline_ifp_fetch_ctrl.sv | 69 ++++++
 tb/tb_pipeline_ifp_fetch_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pipeline_ifp_pkg.sv
// pipeline_ifp_pkg: shared types and constants for the instruction-fetch-prepare stage
package pipeline_ifp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} ifp_state_t;
  localparam int INSTR_BYTES = 4;
  localparam logic [63:0] ROM_BASE_DEF = 64'h0000_0000_0000_0000;
  localparam logic [63:0] ROM_SIZE_DEF = 64'h0000_0000_0000_1000;
endpackage

// File: rtl/pipeline_ifp_fetch_ctrl_addr_decode.sv
// ifp_addr_decode: maps an address to the ROM (0) or DRAM (1) channel
// Ports: i_addr = byte address, o_dram_sel = 1 when i_addr lies outside the ROM window
module ifp_addr_decode import pipeline_ifp_pkg::*; #(
  parameter logic [63:0] ROM_BASE = ROM_BASE_DEF,
  parameter logic [63:0] ROM_SIZE = ROM_SIZE_DEF
) (
  input  logic [63:0] i_addr,
  output logic        o_dram_sel
);
  // Unsigned offset wraps to a huge value below ROM_BASE, so one compare covers both bounds
  assign o_dram_sel = (i_addr - ROM_BASE) >= ROM_SIZE;
endmodule

// File: rtl/pipeline_ifp_fetch_ctrl.sv
// pipeline_ifp_fetch_ctrl: fetch PC owner, ROM/DRAM channel select and DRAM fetch handshake
// Ports: clk, reset (async active-low), stall/redirect_valid/redirect_pc from later stages,
// pc_IFP/if_channel_sel/rom_addr to the fetch-ready stage, dram_req/dram_addr/dram_data_ready
// to the DRAM side, fetch_stall to the hazard unit.
// Optional macro PIPELINE_IFP_MISALIGN_EN adds fetch_misalign and suppresses misaligned fetches.
module pipeline_ifp_fetch_ctrl import pipeline_ifp_pkg::*; #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter logic [63:0] ROM_BASE = ROM_BASE_DEF,
  parameter logic [63:0] ROM_SIZE = ROM_SIZE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc_IFP,
  output logic        if_channel_sel,
  output logic [63:0] rom_addr,
  output logic        dram_req,
  output logic [63:0] dram_addr,
  input  logic        dram_data_ready,
  output logic        fetch_stall
`ifdef PIPELINE_IFP_MISALIGN_EN
  ,
  output logic        fetch_misalign
`endif
);
  logic [63:0] r_pc;
  ifp_state_t  r_state;
  logic        w_mis;
  logic        w_complete;
  // Low PC bits never steer the channel
  ifp_addr_decode #(.ROM_BASE(ROM_BASE), .ROM_SIZE(ROM_SIZE)) u_dec (
    .i_addr     ({r_pc[63:2], 2'b00}),
    .o_dram_sel (if_channel_sel)
  );
`ifdef PIPELINE_IFP_MISALIGN_EN
  assign w_mis = |r_pc[1:0];
  assign fetch_misalign = w_mis;
`else
  assign w_mis = 1'b0;
`endif
  assign pc_IFP      = r_pc;
  assign rom_addr    = r_pc;
  assign dram_req    = !w_mis && (r_state == WAIT || (r_state == IDLE && if_channel_sel));
  assign dram_addr   = dram_req ? r_pc : '0;
  assign fetch_stall = r_state == DISCARD || (dram_req && !dram_data_ready);
  // ROM completes at once from IDLE; DRAM completes on ready from IDLE or WAIT
  assign w_complete  = !w_mis && (r_state == IDLE ? (!if_channel_sel || dram_data_ready)
                                                  : (r_state == WAIT && dram_data_ready));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= RESET_PC;
      r_state <= IDLE;
    end else begin
      r_pc <= redirect_valid ? redirect_pc :
              (stall || fetch_stall) ? r_pc :
              w_complete ? r_pc + 64'(INSTR_BYTES) : r_pc;
      case (r_state)
        IDLE:    if (dram_req && !dram_data_ready) r_state <= WAIT;
        // Ready together with a redirect belongs to the old PC, so nothing is left to discard
        WAIT:    if (dram_data_ready) r_state <= IDLE;
                 else if (redirect_valid) r_state <= DISCARD;
        DISCARD: if (dram_data_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_ifp_fetch_ctrl.sv
// tb_pipeline_ifp_fetch_ctrl: directed vector table, reset corner case and randomized model check
module tb_pipeline_ifp_fetch_ctrl;
  localparam logic [63:0] RB = 64'h0;
  localparam logic [63:0] RS = 64'h1000;
  logic        clk = 0, reset = 0, stall = 0, redirect_valid = 0, dram_data_ready = 0;
  logic [63:0] redirect_pc = '0, pc_IFP, rom_addr, dram_addr;
  logic        if_channel_sel, dram_req, fetch_stall;
  int          checks = 0, errors = 0;
  typedef struct {
    logic st, rv;
    logic [63:0] rpc;
    logic rdy;
    logic [63:0] pc;
    logic sel, req, fs;
  } vec_t;
  vec_t vq[$];
  logic [63:0] m_pc;
  bit m_pend, m_drop;
  always #5 clk = ~clk;
  pipeline_ifp_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc_IFP(pc_IFP), .if_channel_sel(if_channel_sel),
    .rom_addr(rom_addr), .dram_req(dram_req), .dram_addr(dram_addr),
    .dram_data_ready(dram_data_ready), .fetch_stall(fetch_stall)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic add(input logic st, input logic rv, input logic [63:0] rpc, input logic rdy,
                     input logic [63:0] pc, input logic sel, input logic req, input logic fs);
    vec_t e;
    e.st = st; e.rv = rv; e.rpc = rpc; e.rdy = rdy; e.pc = pc; e.sel = sel; e.req = req; e.fs = fs;
    vq.push_back(e);
  endtask
  task automatic drive(input logic st, input logic rv, input logic [63:0] rpc, input logic rdy);
    stall = st; redirect_valid = rv; redirect_pc = rpc; dram_data_ready = rdy;
  endtask
  function automatic bit in_rom(input logic [63:0] a);
    logic [63:0] w;
    w = {a[63:2], 2'b00};
    return (w - RB) < RS;
  endfunction
  initial begin
    #2;
    chk("reset_pc", pc_IFP, 64'h0);
    chk("reset_sel", 64'(if_channel_sel), 64'h0);
    chk("reset_req", 64'(dram_req), 64'h0);
    chk("reset_fstall", 64'(fetch_stall), 64'h0);
    //   st rv rpc                      rdy pc                      sel req fs
    add(0, 0, 64'h0,                    0, 64'h0,                    0, 0, 0);
    add(0, 0, 64'h0,                    0, 64'h4,                    0, 0, 0);
    add(0, 0, 64'h0,                    0, 64'h8,                    0, 0, 0);
    add(0, 1, 64'h8000_0000,            0, 64'hC,                    0, 0, 0);
    add(0, 0, 64'h0,                    0, 64'h8000_0000,            1, 1, 1);
    add(0, 0, 64'h0,                    0, 64'h8000_0000,            1, 1, 1);
    add(0, 0, 64'h0,                    0, 64'h8000_0000,            1, 1, 1);
    add(0, 0, 64'h0,                    1, 64'h8000_0000,            1, 1, 0);
    add(0, 0, 64'h0,                    0, 64'h8000_0004,            1, 1, 1);
    add(0, 1, 64'h100,                  0, 64'h8000_0004,            1, 1, 1);
    add(0, 0, 64'h0,                    0, 64'h100,                  0, 0, 1);
    add(0, 0, 64'h0,                    1, 64'h100,                  0, 0, 1);
    add(0, 0, 64'h0,                    0, 64'h100,                  0, 0, 0);
    add(0, 1, 64'h8000_0000,            0, 64'h104,                  0, 0, 0);
    add(0, 0, 64'h0,                    0, 64'h8000_0000,            1, 1, 1);
    add(0, 1, 64'h200,                  1, 64'h8000_0000,            1, 1, 0);
    add(0, 1, 64'h20,                   0, 64'h200,                  0, 0, 0);
    add(1, 0, 64'h0,                    0, 64'h20,                   0, 0, 0);
    add(1, 0, 64'h0,                    0, 64'h20,                   0, 0, 0);
    add(1, 1, 64'h40,                   0, 64'h20,                   0, 0, 0);
    add(1, 0, 64'h0,                    0, 64'h40,                   0, 0, 0);
    add(1, 0, 64'h0,                    0, 64'h40,                   0, 0, 0);
    add(0, 0, 64'h0,                    0, 64'h40,                   0, 0, 0);
    add(0, 1, 64'hFFC,                  0, 64'h44,                   0, 0, 0);
    add(0, 0, 64'h0,                    0, 64'hFFC,                  0, 0, 0);
    add(0, 0, 64'h0,                    1, 64'h1000,                 1, 1, 0);
    add(0, 0, 64'h0,                    0, 64'h1004,                 1, 1, 1);
    add(1, 0, 64'h0,                    1, 64'h1004,                 1, 1, 0);
    add(0, 0, 64'h0,                    1, 64'h1004,                 1, 1, 0);
    add(0, 1, 64'hFFFF_FFFF_FFFF_FFFC,  1, 64'h1008,                 1, 1, 0);
    add(0, 0, 64'h0,                    1, 64'hFFFF_FFFF_FFFF_FFFC,  1, 1, 0);
    add(0, 1, 64'h8000_0000,            0, 64'h0,                    0, 0, 0);
    add(0, 0, 64'h0,                    0, 64'h8000_0000,            1, 1, 1);
    @(negedge clk) reset = 1;
    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].rv, vq[i].rpc, vq[i].rdy);
      #1;
      chk($sformatf("vec%0d_pc", i), pc_IFP, vq[i].pc);
      chk($sformatf("vec%0d_sel", i), 64'(if_channel_sel), 64'(vq[i].sel));
      chk($sformatf("vec%0d_req", i), 64'(dram_req), 64'(vq[i].req));
      chk($sformatf("vec%0d_addr", i), dram_addr, vq[i].req ? vq[i].pc : 64'h0);
      chk($sformatf("vec%0d_fstall", i), 64'(fetch_stall), 64'(vq[i].fs));
      @(posedge clk); #1;
    end
    drive(0, 0, 64'h0, 0);
    #1;
    chk("wait_req", 64'(dram_req), 64'h1);
    chk("wait_fstall", 64'(fetch_stall), 64'h1);
    reset = 0;
    #1;
    chk("midreset_pc", pc_IFP, 64'h0);
    chk("midreset_req", 64'(dram_req), 64'h0);
    chk("midreset_addr", dram_addr, 64'h0);
    chk("midreset_fstall", 64'(fetch_stall), 64'h0);
    @(posedge clk); #1;
    chk("held_reset_pc", pc_IFP, 64'h0);
    @(negedge clk) reset = 1;
    m_pc = 64'h0; m_pend = 0; m_drop = 0;
    for (int n = 0; n < 600; n++) begin
      logic st, rv, rdy, rom, req, fs, comp;
      logic [63:0] rpc;
      int pick;
      st  = $urandom_range(0, 4) == 0;
      rv  = $urandom_range(0, 9) == 0;
      rdy = $urandom_range(0, 2) == 0;
      pick = $urandom_range(0, 3);
      rpc = pick == 0 ? 64'($urandom_range(0, 'h3FF)) * 4 :
            pick == 1 ? 64'h8000_0000 + 64'($urandom_range(0, 255)) * 4 :
            pick == 2 ? ($urandom_range(0, 1) ? 64'hFFC : 64'h1000) :
                        {32'($urandom), 32'($urandom)};
      drive(st, rv, rpc, rdy);
      #1;
      rom  = in_rom(m_pc);
      req  = !m_drop && (m_pend || !rom);
      fs   = m_drop || (req && !rdy);
      comp = !m_drop && (m_pend ? rdy : (rom || rdy));
      chk("rnd_pc", pc_IFP, m_pc);
      chk("rnd_rom_addr", rom_addr, m_pc);
      chk("rnd_sel", 64'(if_channel_sel), 64'(!rom));
      chk("rnd_req", 64'(dram_req), 64'(req));
      chk("rnd_addr", dram_addr, req ? m_pc : 64'h0);
      chk("rnd_fstall", 64'(fetch_stall), 64'(fs));
      if (m_drop) begin
        if (rdy) m_drop = 0;
      end else if (m_pend) begin
        if (rdy) m_pend = 0;
        else if (rv) begin m_pend = 0; m_drop = 1; end
      end else if (req && !rdy) m_pend = 1;
      m_pc = rv ? rpc : (st || fs) ? m_pc : comp ? m_pc + 64'd4 : m_pc;
      @(posedge clk); #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
